// File: rtl/decode_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage_if
// Description : Bundles the fetch-side handshake, the execute-side handshake,
//               the decoded control fields and the flush/resume controls of
//               decode_stage.
//               slave  : view used by decode_stage (consumes fetch, produces
//                        the decoded bundle).
//               master : view used by the surrounding pipeline or a bench.
// Ports       : in_valid/in_ready, in_instr[31:0], in_pc[XLEN-1:0], flush,
//               resume, out_valid/out_ready, out_pc, rs1/rs2/rd, rf_wsrc,
//               alu_imm_b, alu_pc_a, alu_alt, alu_op, imm, cmp_src, cmp_inv,
//               bra_mode, mem_en, mem_rw, mem_func, md_en, md_op, illegal, brk
// Revision    : 1.0 - initial release
// ============================================================================
interface decode_stage_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic [XLEN-1:0]   in_pc;
  logic              flush;
  logic              resume;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_pc;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic [REG_AW-1:0] rd;
  logic [1:0]        rf_wsrc;
  logic              alu_imm_b;
  logic              alu_pc_a;
  logic              alu_alt;
  logic [2:0]        alu_op;
  logic [XLEN-1:0]   imm;
  logic [1:0]        cmp_src;
  logic              cmp_inv;
  logic [1:0]        bra_mode;
  logic              mem_en;
  logic              mem_rw;
  logic [2:0]        mem_func;
  logic              md_en;
  logic [2:0]        md_op;
  logic              illegal;
  logic              brk;

  modport slave (
    input  in_valid, in_instr, in_pc, flush, resume, out_ready,
    output in_ready, out_valid, out_pc, rs1, rs2, rd, rf_wsrc,
           alu_imm_b, alu_pc_a, alu_alt, alu_op, imm, cmp_src, cmp_inv,
           bra_mode, mem_en, mem_rw, mem_func, md_en, md_op, illegal, brk
  );

  modport master (
    output in_valid, in_instr, in_pc, flush, resume, out_ready,
    input  in_ready, out_valid, out_pc, rs1, rs2, rd, rf_wsrc,
           alu_imm_b, alu_pc_a, alu_alt, alu_op, imm, cmp_src, cmp_inv,
           bra_mode, mem_en, mem_rw, mem_func, md_en, md_op, illegal, brk
  );
endinterface
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : Single-entry RISC-V decode register. An accepted instruction
//               is decoded combinationally and captured; the decoded bundle
//               is presented one cycle later and held while execute stalls.
//               Handing an illegal or breakpoint bundle to execute parks the
//               stage in HALT until resume is pulsed.
// Ports       : clk  - rising-edge clock
//               rst  - synchronous active-high reset
//               bus  - decode_stage_if.slave (fetch/execute handshakes,
//                      decoded fields, flush, resume)
// Parameters  : XLEN (32 or 64), REG_AW (register index width)
// Options     : DECODE_RV32M_EN - when defined, OP with funct7=0000001 is
//               decoded as a multiply/divide request (md_en/md_op); when
//               undefined md_en/md_op are tied 0 and that encoding is illegal.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  wire                  clk,
  input  wire                  rst,
  decode_stage_if.slave        bus
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;

  typedef struct packed {
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [1:0]        rf_wsrc;
    logic              alu_imm_b;
    logic              alu_pc_a;
    logic              alu_alt;
    logic [2:0]        alu_op;
    logic [XLEN-1:0]   imm;
    logic [1:0]        cmp_src;
    logic              cmp_inv;
    logic [1:0]        bra_mode;
    logic              mem_en;
    logic              mem_rw;
    logic [2:0]        mem_func;
    logic              illegal;
    logic              brk;
  } fields_t;

  // Every immediate format is first assembled as a 32-bit value and then
  // sign-extended from bit 31 to XLEN.
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  logic [0:0]      state;
  logic            valid;
  fields_t         held;
  logic [XLEN-1:0] held_pc;
  fields_t         dec;
  logic            dec_ill;
  logic            accept;
  logic            out_fire;

  logic [31:0] ins;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;

  assign ins = bus.in_instr;
  assign opc = ins[6:0];
  assign f3  = ins[14:12];
  assign f7  = ins[31:25];

`ifdef DECODE_RV32M_EN
  logic       dec_md_en;
  logic [2:0] dec_md_op;
  logic       held_md_en;
  logic [2:0] held_md_op;
`endif

  // --------------------------------------------------------------------------
  // Combinational decode of the presented instruction
  // --------------------------------------------------------------------------
  always_comb begin
    dec     = '0;
    dec_ill = 1'b0;
`ifdef DECODE_RV32M_EN
    dec_md_en = 1'b0;
    dec_md_op = 3'b000;
`endif
    case (opc)
      OPC_LUI: begin
        dec.rd        = REG_AW'(ins[11:7]);
        dec.imm       = sext32({ins[31:12], 12'b0});
        dec.alu_imm_b = 1'b1;
        dec.rf_wsrc   = 2'b01;
      end
      OPC_AUIPC: begin
        dec.rd        = REG_AW'(ins[11:7]);
        dec.imm       = sext32({ins[31:12], 12'b0});
        dec.alu_pc_a  = 1'b1;
        dec.alu_imm_b = 1'b1;
        dec.rf_wsrc   = 2'b01;
      end
      OPC_JAL: begin
        dec.rd       = REG_AW'(ins[11:7]);
        dec.imm      = sext32({{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0});
        dec.bra_mode = 2'b01;
        dec.rf_wsrc  = 2'b11;
      end
      OPC_JALR: begin
        // Target is rs1 + imm through the ALU.
        dec.rd        = REG_AW'(ins[11:7]);
        dec.rs1       = REG_AW'(ins[19:15]);
        dec.imm       = sext32({{20{ins[31]}}, ins[31:20]});
        dec.alu_imm_b = 1'b1;
        dec.bra_mode  = 2'b11;
        dec.rf_wsrc   = 2'b11;
        dec_ill       = (f3 != 3'b000);
      end
      OPC_BRANCH: begin
        // Comparison runs on the ALU in subtract mode.
        dec.rs1      = REG_AW'(ins[19:15]);
        dec.rs2      = REG_AW'(ins[24:20]);
        dec.imm      = sext32({{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
        dec.bra_mode = 2'b10;
        dec.alu_alt  = 1'b1;
        dec.cmp_src  = f3[2:1];
        dec.cmp_inv  = f3[0];
        dec_ill      = (f3[2:1] == 2'b01);
      end
      OPC_LOAD: begin
        dec.rd        = REG_AW'(ins[11:7]);
        dec.rs1       = REG_AW'(ins[19:15]);
        dec.imm       = sext32({{20{ins[31]}}, ins[31:20]});
        dec.alu_imm_b = 1'b1;
        dec.mem_en    = 1'b1;
        dec.mem_func  = f3;
        dec.rf_wsrc   = 2'b10;
        // Doubleword and unsigned-word loads only exist on a 64-bit datapath.
        dec_ill       = (XLEN == 32) && ((f3 == 3'b011) || (f3[2:1] == 2'b11));
      end
      OPC_STORE: begin
        dec.rs1       = REG_AW'(ins[19:15]);
        dec.rs2       = REG_AW'(ins[24:20]);
        dec.imm       = sext32({{20{ins[31]}}, ins[31:25], ins[11:7]});
        dec.alu_imm_b = 1'b1;
        dec.mem_en    = 1'b1;
        dec.mem_rw    = 1'b1;
        dec.mem_func  = f3;
        dec_ill       = (XLEN == 32) && (f3 >= 3'b011);
      end
      OPC_OPIMM: begin
        // instr[30] selects SRAI over SRLI; for other funct3 it is immediate data.
        dec.rd        = REG_AW'(ins[11:7]);
        dec.rs1       = REG_AW'(ins[19:15]);
        dec.imm       = sext32({{20{ins[31]}}, ins[31:20]});
        dec.alu_imm_b = 1'b1;
        dec.alu_op    = f3;
        dec.alu_alt   = (f3 == 3'b101) ? ins[30] : 1'b0;
        dec.rf_wsrc   = 2'b01;
      end
      OPC_OP: begin
        dec.rd      = REG_AW'(ins[11:7]);
        dec.rs1     = REG_AW'(ins[19:15]);
        dec.rs2     = REG_AW'(ins[24:20]);
        dec.rf_wsrc = 2'b01;
        if ((f7 == 7'b0000000) || (f7 == 7'b0100000)) begin
          dec.alu_op  = f3;
          dec.alu_alt = ins[30];
        end
`ifdef DECODE_RV32M_EN
        else if (f7 == 7'b0000001) begin
          dec_md_en = 1'b1;
          dec_md_op = f3;
        end
`endif
        else begin
          dec_ill = 1'b1;
        end
      end
      OPC_SYSTEM: begin
        if (ins == EBREAK_WORD) begin
          dec.brk = 1'b1;
        end else begin
          dec_ill = 1'b1;
        end
      end
      default: dec_ill = 1'b1;
    endcase

    // An illegal bundle carries nothing but the flag.
    if (dec_ill) begin
      dec         = '0;
      dec.illegal = 1'b1;
`ifdef DECODE_RV32M_EN
      dec_md_en   = 1'b0;
      dec_md_op   = 3'b000;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Handshakes
  // --------------------------------------------------------------------------
  // rst is included so the stage refuses fetch for the whole reset cycle,
  // whatever it held beforehand.
  assign bus.in_ready = !rst && (state == ST_RUN) && (!valid || bus.out_ready) && !bus.flush;
  assign accept       = bus.in_valid && bus.in_ready;
  // A flush cancels the bundle, so it never counts as handed to execute.
  assign out_fire     = valid && bus.out_ready && !bus.flush;

  // --------------------------------------------------------------------------
  // Run/halt control and the output register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_RUN;
      valid   <= 1'b0;
      held    <= '0;
      held_pc <= '0;
`ifdef DECODE_RV32M_EN
      held_md_en <= 1'b0;
      held_md_op <= 3'b000;
`endif
    end else begin
      case (state)
        ST_RUN:  if (out_fire && (held.illegal || held.brk)) state <= ST_HALT;
        ST_HALT: if (bus.resume) state <= ST_RUN;
        default: state <= ST_RUN;
      endcase

      if (bus.flush) begin
        valid <= 1'b0;
      end else if (accept) begin
        valid   <= 1'b1;
        held    <= dec;
        held_pc <= bus.in_pc;
`ifdef DECODE_RV32M_EN
        held_md_en <= dec_md_en;
        held_md_op <= dec_md_op;
`endif
      end else if (out_fire) begin
        valid <= 1'b0;
      end
    end
  end

  assign bus.out_valid = valid;
  assign bus.out_pc    = held_pc;
  assign bus.rs1       = held.rs1;
  assign bus.rs2       = held.rs2;
  assign bus.rd        = held.rd;
  assign bus.rf_wsrc   = held.rf_wsrc;
  assign bus.alu_imm_b = held.alu_imm_b;
  assign bus.alu_pc_a  = held.alu_pc_a;
  assign bus.alu_alt   = held.alu_alt;
  assign bus.alu_op    = held.alu_op;
  assign bus.imm       = held.imm;
  assign bus.cmp_src   = held.cmp_src;
  assign bus.cmp_inv   = held.cmp_inv;
  assign bus.bra_mode  = held.bra_mode;
  assign bus.mem_en    = held.mem_en;
  assign bus.mem_rw    = held.mem_rw;
  assign bus.mem_func  = held.mem_func;
  assign bus.illegal   = held.illegal;
  assign bus.brk       = held.brk;

`ifdef DECODE_RV32M_EN
  assign bus.md_en = held_md_en;
  assign bus.md_op = held_md_op;
`else
  assign bus.md_en = 1'b0;
  assign bus.md_op = 3'b000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_stage
// Description : Directed self-checking bench for decode_stage (XLEN=32).
//               Expected values are hand-decoded from the instruction words.
//               Honours DECODE_RV32M_EN for the multiply/divide vector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  decode_stage_if #(.XLEN(32), .REG_AW(5)) bus ();

  decode_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] instr, input logic [31:0] pc);
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    bus.in_pc    = pc;
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_instr = 32'h0;
    bus.in_pc    = 32'h0;
    bus.flush    = 1'b0;
    bus.resume   = 1'b0;
    bus.out_ready = 1'b1;

    // ---------------- reset ----------------
    step();
    #1;
    chk("rst_in_ready", {63'b0, bus.in_ready}, 64'd0);
    step();
    chk("rst_out_valid", {63'b0, bus.out_valid}, 64'd0);
    chk("rst_imm", {32'b0, bus.imm}, 64'd0);
    chk("rst_illegal", {63'b0, bus.illegal}, 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {63'b0, bus.in_ready}, 64'd1);

    // ---------------- LUI x4, 0x12345 ----------------
    present(32'h1234_5237, 32'h0000_0100);
    step();
    bus.in_valid = 1'b0;
    chk("lui_valid", {63'b0, bus.out_valid}, 64'd1);
    chk("lui_rd", {59'b0, bus.rd}, 64'd4);
    chk("lui_imm", {32'b0, bus.imm}, 64'h1234_5000);
    chk("lui_wsrc", {62'b0, bus.rf_wsrc}, 64'd1);
    chk("lui_immb", {63'b0, bus.alu_imm_b}, 64'd1);
    chk("lui_rs1", {59'b0, bus.rs1}, 64'd0);
    chk("lui_pc", {32'b0, bus.out_pc}, 64'h100);
    step();
    chk("lui_drained", {63'b0, bus.out_valid}, 64'd0);

    // ---------------- ADDI x1, x0, -1 held under stall ----------------
    bus.out_ready = 1'b0;
    present(32'hFFF0_0093, 32'h0000_0104);
    step();
    present(32'h1234_5237, 32'h0000_0108);   // waits behind the stalled bundle
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_valid", {63'b0, bus.out_valid}, 64'd1);
      chk("stall_imm", {32'b0, bus.imm}, 64'hFFFF_FFFF);
      chk("stall_rd", {59'b0, bus.rd}, 64'd1);
      chk("stall_in_ready", {63'b0, bus.in_ready}, 64'd0);
      step();
    end
    chk("stall_pc", {32'b0, bus.out_pc}, 64'h104);
    bus.out_ready = 1'b1;
    #1;
    chk("unstall_in_ready", {63'b0, bus.in_ready}, 64'd1);
    step();
    bus.in_valid = 1'b0;
    // Simultaneous in/out transfer: the register holds the LUI now.
    chk("replace_valid", {63'b0, bus.out_valid}, 64'd1);
    chk("replace_rd", {59'b0, bus.rd}, 64'd4);
    chk("replace_pc", {32'b0, bus.out_pc}, 64'h108);
    step();

    // ---------------- all-zero word is illegal ----------------
    present(32'h0000_0000, 32'h0000_0200);
    step();
    bus.in_valid = 1'b0;
    chk("zero_illegal", {63'b0, bus.illegal}, 64'd1);
    chk("zero_wsrc", {62'b0, bus.rf_wsrc}, 64'd0);
    chk("zero_mem_en", {63'b0, bus.mem_en}, 64'd0);
    step();
    #1;
    chk("halt_in_ready", {63'b0, bus.in_ready}, 64'd0);
    step();
    chk("halt_in_ready2", {63'b0, bus.in_ready}, 64'd0);
    bus.resume = 1'b1;
    step();
    bus.resume = 1'b0;
    #1;
    chk("resume_in_ready", {63'b0, bus.in_ready}, 64'd1);

    // ---------------- EBREAK ----------------
    present(32'h0010_0073, 32'h0000_0300);
    step();
    bus.in_valid = 1'b0;
    chk("brk_brk", {63'b0, bus.brk}, 64'd1);
    chk("brk_illegal", {63'b0, bus.illegal}, 64'd0);
    step();
    #1;
    chk("brk_halt", {63'b0, bus.in_ready}, 64'd0);
    bus.resume = 1'b1;
    step();
    bus.resume = 1'b0;

    // ---------------- MUL x3, x1, x2 ----------------
    present(32'h0220_81B3, 32'h0000_0400);
    step();
    bus.in_valid = 1'b0;
`ifdef DECODE_RV32M_EN
    chk("mul_md_en", {63'b0, bus.md_en}, 64'd1);
    chk("mul_md_op", {61'b0, bus.md_op}, 64'd0);
    chk("mul_rd", {59'b0, bus.rd}, 64'd3);
    chk("mul_illegal", {63'b0, bus.illegal}, 64'd0);
    step();
`else
    chk("mul_illegal", {63'b0, bus.illegal}, 64'd1);
    chk("mul_md_en", {63'b0, bus.md_en}, 64'd0);
    chk("mul_rd", {59'b0, bus.rd}, 64'd0);
    step();
    bus.resume = 1'b1;
    step();
    bus.resume = 1'b0;
`endif

    // ---------------- BNE x1, x2, -4 ----------------
    present(32'hFE20_9EE3, 32'h0000_0500);
    step();
    present(32'h0020_A423, 32'h0000_0504);   // SW x2, 8(x1) follows back-to-back
    chk("bne_bra", {62'b0, bus.bra_mode}, 64'd2);
    chk("bne_alt", {63'b0, bus.alu_alt}, 64'd1);
    chk("bne_cmp_src", {62'b0, bus.cmp_src}, 64'd0);
    chk("bne_cmp_inv", {63'b0, bus.cmp_inv}, 64'd1);
    chk("bne_imm", {32'b0, bus.imm}, 64'hFFFF_FFFC);
    chk("bne_rs2", {59'b0, bus.rs2}, 64'd2);
    chk("bne_rd", {59'b0, bus.rd}, 64'd0);
    step();
    present(32'h0080_00EF, 32'h0000_0508);   // JAL x1, +8
    chk("sw_mem", {62'b0, bus.mem_en, bus.mem_rw}, 64'd3);
    chk("sw_func", {61'b0, bus.mem_func}, 64'd2);
    chk("sw_imm", {32'b0, bus.imm}, 64'd8);
    chk("sw_wsrc", {62'b0, bus.rf_wsrc}, 64'd0);
    chk("sw_bra_cleared", {62'b0, bus.bra_mode}, 64'd0);
    step();
    bus.in_valid = 1'b0;
    chk("jal_bra", {62'b0, bus.bra_mode}, 64'd1);
    chk("jal_wsrc", {62'b0, bus.rf_wsrc}, 64'd3);
    chk("jal_imm", {32'b0, bus.imm}, 64'd8);
    chk("jal_mem_cleared", {63'b0, bus.mem_en}, 64'd0);
    step();

    // ---------------- LD on a 32-bit datapath is illegal ----------------
    present(32'h0000_B283, 32'h0000_0600);
    step();
    bus.in_valid = 1'b0;
    chk("ld_illegal", {63'b0, bus.illegal}, 64'd1);
    chk("ld_mem_en", {63'b0, bus.mem_en}, 64'd0);
    step();
    bus.resume = 1'b1;
    step();
    bus.resume = 1'b0;

    // ---------------- flush beats an output transfer ----------------
    present(32'h0010_0073, 32'h0000_0700);
    step();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b1;
    #1;
    chk("flush_in_ready", {63'b0, bus.in_ready}, 64'd0);
    step();
    bus.flush = 1'b0;
    chk("flush_valid", {63'b0, bus.out_valid}, 64'd0);
    #1;
    // The breakpoint was never handed over, so the stage is still running.
    chk("flush_no_halt", {63'b0, bus.in_ready}, 64'd1);

    // ---------------- reset in the middle of a stall ----------------
    bus.out_ready = 1'b0;
    present(32'hFFF0_0093, 32'h0000_0800);
    step();
    bus.in_valid = 1'b0;
    chk("pre_rst_valid", {63'b0, bus.out_valid}, 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", {63'b0, bus.in_ready}, 64'd0);
    step();
    rst = 1'b0;
    chk("stall_rst_valid", {63'b0, bus.out_valid}, 64'd0);
    chk("stall_rst_imm", {32'b0, bus.imm}, 64'd0);
    chk("stall_rst_rd", {59'b0, bus.rd}, 64'd0);
    chk("stall_rst_ctl", {58'b0, bus.rf_wsrc, bus.alu_imm_b, bus.bra_mode, bus.illegal}, 64'd0);
    chk("stall_rst_pc", {32'b0, bus.out_pc}, 64'd0);
    #1;
    chk("stall_rst_ready_after", {63'b0, bus.in_ready}, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
